fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter AW, default 4, RAM address width; DEPTH = 2^AW entries.
REQ-002 Parameter AF_LVL, default 2^AW-2, almost_full threshold; legal range 1..DEPTH-1.
REQ-003 Parameter AE_LVL, default 2, almost_empty threshold; legal range 1..DEPTH-1.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 clr  input  1  synchronous soft clear of pointers and error flags.
REQ-007 wr_req  input  1  requester wants to push one word this cycle.
REQ-008 rd_req  input  1  requester wants to pop one word this cycle.
REQ-009 wr_en  output  1  qualified write strobe to RAM and write-pointer counter.
REQ-010 rd_en  output  1  qualified read strobe to RAM and read-pointer counter.
REQ-011 waddr  output  AW  RAM write address (low AW bits of write pointer).
REQ-012 raddr  output  AW  RAM read address (low AW bits of read pointer).
REQ-013 level  output  AW+1  current occupancy, 0..DEPTH.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write and read pointers SHALL be AW+1-bit registered binary counters; each increments by 1 only on its strobe and wraps 2^(AW+1)-1 -> 0.
REQ-017 wr_en SHALL equal wr_req & ~full & ~clr, combinational, same cycle.
REQ-018 rd_en SHALL equal rd_req & ~empty & ~clr, combinational, same cycle.
REQ-019 level SHALL equal (wptr - rptr) modulo 2^(AW+1), derived from registered pointers only.
REQ-020 empty SHALL be 1 iff level == 0; full SHALL be 1 iff level == DEPTH.
REQ-021 almost_full SHALL be 1 iff level >= AF_LVL; almost_empty SHALL be 1 iff level <= AE_LVL.
REQ-022 All flags and level SHALL reflect a strobe one cycle after the edge where it was sampled (no look-ahead).
REQ-023 Simultaneous wr_en and rd_en SHALL advance both pointers; level unchanged.
REQ-024 When full, simultaneous wr_req and rd_req: read proceeds, write blocked; next cycle level = DEPTH-1.
REQ-025 When empty, simultaneous wr_req and rd_req: write proceeds, read blocked; next cycle level = 1.
REQ-026 overflow SHALL set on any edge where wr_req & full & ~clr, and hold until clr or reset.
REQ-027 underflow SHALL set on any edge where rd_req & empty & ~clr, and hold until clr or reset.
REQ-028 clr high at an edge SHALL zero both pointers and both error flags; requests in that cycle are discarded.
REQ-029 Blocked requests SHALL not be queued or retried; requester re-asserts.

Reset
REQ-030 rstn low at an edge SHALL zero both pointers, overflow and underflow; rstn has priority over clr and requests.
REQ-031 After reset: level=0, empty=1, almost_empty=1, full=0, almost_full=0, waddr=raddr=0, wr_en/rd_en follow REQ-017/018.
REQ-032 Reset asserted mid-operation SHALL discard all occupancy; no strobe is issued for requests during reset cycles that take effect afterwards.

Verification (AW=2, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-033 Reset, then 4 consecutive wr_req -> waddr 0,1,2,3; level 1..4; almost_full at level 3; full=1 after 4th edge.
REQ-034 Full, 5th wr_req -> wr_en=0, overflow=1 next cycle, level stays 4; overflow holds until clr pulse.
REQ-035 Full, wr_req & rd_req together -> rd_en=1, wr_en=0, level 3 next; empty, both together -> wr_en=1, rd_en=0, level 1.
REQ-036 Run 10 write/read pairs at level 2 -> addresses wrap 3->0, pointers wrap 7->0, level constant 2, no error flags.
REQ-037 Level 3 then clr for one cycle with wr_req high -> level 0, empty=1, wr_en=0 that cycle, flags cleared.
REQ-038 Level 2 then rstn low one cycle -> all outputs at REQ-031 values; rd_req on empty -> underflow=1.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: qualifies push/pop requests, tracks occupancy
// with AW+1-bit binary pointers and raises status and sticky error flags.
module fifo_ctrl #(
  parameter int AW     = 4,
  parameter int AF_LVL = (1 << AW) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  // Occupancy comes only from registered pointers, so flags lag strobes by one edge.
  assign level        = wptr_q - rptr_q;
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign wr_en = wr_req & ~full & ~clr;
  assign rd_en = rd_req & ~empty & ~clr;

  assign waddr     = wptr_q[AW-1:0];
  assign raddr     = rptr_q[AW-1:0];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ONE;
      if (rd_en) rptr_d = rptr_q + ONE;
      if (wr_req && full)  overflow_d  = 1'b1;
      if (rd_req && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (AW=2): directed scenarios then random traffic,
// compared against an occupancy-count reference model.
module tb_fifo_ctrl;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic rstn, clr, wr_req, rd_req;
  logic wr_en, rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] waddr, raddr;
  logic [AW:0] level;

  int total = 0;
  int bad = 0;

  // Reference state: occupancy count, total pushes/pops modulo 8, sticky errors.
  int m_cnt, m_wr, m_rd;
  bit m_ovf, m_udf;

  fifo_ctrl #(.AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .wr_req(wr_req), .rd_req(rd_req),
    .wr_en(wr_en), .rd_en(rd_en), .waddr(waddr), .raddr(raddr), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic cyc(input bit w, input bit r, input bit c, input bit n);
    bit ew, er;
    wr_req = w; rd_req = r; clr = c; rstn = n;
    #1;
    ew = w && (m_cnt != DEPTH) && !c;
    er = r && (m_cnt != 0) && !c;
    chk("wr_en", {31'd0, wr_en}, {31'd0, ew});
    chk("rd_en", {31'd0, rd_en}, {31'd0, er});
    chk("level", {29'd0, level}, m_cnt);
    chk("waddr", {30'd0, waddr}, m_wr % DEPTH);
    chk("raddr", {30'd0, raddr}, m_rd % DEPTH);
    chk("full", {31'd0, full}, (m_cnt == DEPTH));
    chk("empty", {31'd0, empty}, (m_cnt == 0));
    chk("almost_full", {31'd0, almost_full}, (m_cnt >= AF));
    chk("almost_empty", {31'd0, almost_empty}, (m_cnt <= AE));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, m_udf});
    $display("txn w=%0b r=%0b clr=%0b rstn=%0b lvl=%0d wr_en=%0b rd_en=%0b ovf=%0b udf=%0b",
             w, r, c, n, level, wr_en, rd_en, overflow, underflow);
    @(posedge clk);
    if (!n) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
    end else if (c) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (w && m_cnt == DEPTH) m_ovf = 1;
      if (r && m_cnt == 0) m_udf = 1;
      if (ew) m_wr = (m_wr + 1) % 8;
      if (er) m_rd = (m_rd + 1) % 8;
      m_cnt = m_cnt + int'(ew) - int'(er);
    end
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
    @(negedge clk);

    cyc(0, 0, 0, 1);                      // reset state
    repeat (4) cyc(1, 0, 0, 1);           // fill to DEPTH
    cyc(1, 0, 0, 1);                      // push while full
    cyc(0, 0, 0, 1);                      // overflow sticks
    cyc(1, 1, 0, 1);                      // full: read wins
    cyc(0, 0, 1, 1);                      // clr
    cyc(1, 1, 0, 1);                      // empty: write wins
    cyc(1, 0, 0, 1);
    repeat (10) cyc(1, 1, 0, 1);          // steady level 2 with wrap
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);                      // clr discards the push
    cyc(0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 0);                      // reset mid-operation
    cyc(0, 1, 0, 1);                      // pop on empty
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 2), 1'($urandom % 2), ($urandom % 32) == 0, ($urandom % 64) != 0);
    cyc(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
